hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Tracks destination register and remaining Tnew for the instructions in E, M and W, and compares them against the Tuse of the instruction in D.
- Drives the pipeline stall, the D-stage and E-stage forwarding mux selects, and the multiply/divide busy interlock.
- Consumes the per-stage Tnew countdown and produces the control every pipeline register and forwarding mux depends on.

Parameters:
- REG_W, 5, register index width.
- MULT_CYCLES, 5, MDU busy cycles for mult/multu.
- DIV_CYCLES, 10, MDU busy cycles for div/divu.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- en  in  1  pipeline advance; 0 freezes all internal state.
- d_valid  in  1  D holds a real instruction.
- d_rs, d_rt  in  REG_W  D source registers.
- d_tuse_rs, d_tuse_rt  in  2  Tuse per source; 3 = operand unused.
- d_a3  in  REG_W  D destination register; 0 = no write.
- d_tnew  in  2  Tnew the instruction will have on entering E.
- d_md_start  in  1  D is mult/multu/div/divu.
- d_md_is_div  in  1  qualifies d_md_start.
- d_md_use  in  1  D is mfhi/mflo/mthi/mtlo.
- stall  out  1  freeze PC/D, bubble into E.
- fwd_rs_d, fwd_rt_d  out  2  D operand source: 0 RF, 1 E, 2 M, 3 W.
- fwd_rs_e, fwd_rt_e  out  2  E operand source: 0 pipeline reg, 2 M, 3 W.
- md_busy  out  1  MDU counter nonzero.

Behaviour:
- State:
  - Entries E, M, W, each {a3, tnew, rs, rt}. E also carries the D-side rs/rt for E forwarding.
  - MDU counter, 4 bits.
- Reset (asynchronous, active-low):
  - All entries become bubbles (a3=0, tnew=0, rs=rt=0); counter=0.
  - Outputs follow combinationally: stall=0 unless D inputs hit live state (none after reset), md_busy=0, all fwd=0.
- Clock edge with en=1:
  - W <= M with tnew-1, saturating at 0.
  - M <= E with tnew-1, saturating at 0.
  - E <= bubble if stall or !d_valid; otherwise {d_a3, d_tnew, d_rs, d_rt}.
- Clock edge with en=0: all state holds; outputs remain combinational on current state.
- Match rule for a source s:
  - Stage X matches if X.a3 == s and s != 0.
  - The youngest matching stage (E > M > W) is the only one considered.
- Data stall:
  - Per source: tuse != 3 and the youngest match has tnew > tuse.
  - stall = data stall on rs OR on rt, OR the MDU interlock.
- D forwarding:
  - If the youngest match has tnew == 0, select its code (1/2/3); otherwise 0.
  - Register $0 always selects 0.
- E forwarding:
  - Uses E.rs/E.rt against M, then W; youngest match wins.
  - Selects 2 or 3 only when that entry's tnew == 0 (always true for W); otherwise 0.
- MDU interlock:
  - md_busy = counter != 0.
  - MDU stall = (d_md_start or d_md_use) and md_busy.
- MDU counter:
  - Loads MULT_CYCLES or DIV_CYCLES on an en edge where d_valid, d_md_start and !stall all hold.
  - Otherwise decrements on en edges while nonzero.
  - A load takes priority over a decrement in the same edge.
- Simultaneous events:
  - Reset dominates everything.
  - stall and en=0 together: state holds (no bubble inserted).
  - Reset asserted mid-divide discards the remaining count.

Decomposition:
- Shared package:
  - TUSE_NONE=3.
  - FWD_RF/FWD_E/FWD_M/FWD_W codes.
  - Stage-entry struct {a3, tnew, rs, rt}.
  - MULT_CYCLES/DIV_CYCLES defaults.
- One sub-module: md_busy_counter (load / decrement / busy).

Test Plan:
1. Reset:
   - Stimulus: issue div, then pull reset low two cycles later.
   - Required: md_busy=0 immediately; all fwd=0; stall=0 with D=mflo after release.
2. Load-use:
   - Stimulus: lw $8 (d_tnew=2), then addu reading $8 with tuse_rs=1.
   - Required: stall=1 for exactly 1 cycle; then fwd_rs_d=0 and E bubble inserted; next cycle fwd_rs_e=3.
3. ALU-to-branch:
   - Stimulus: addu $8 (d_tnew=1), then beq $8 (tuse=0).
   - Required: stall 1 cycle; then fwd_rs_d=2, stall=0.
4. Youngest wins:
   - Stimulus: ori $9 (tnew=1) in M; lui $9 (tnew=0) in E; D reads $9 with tuse=0.
   - Required: fwd_rs_d=1, no stall.
   - Swap the two (tnew=1 entry in E): stall=1.
5. $0 and unused operands:
   - Stimulus: lw $0 then addu reading $0; then tuse=3 reading a pending register.
   - Required: stall=0 and fwd=0 in both cases.
6. MDU and freeze:
   - Stimulus: mult, then mflo in D; then hold en=0 for 3 cycles mid-count.
   - Required: stall for 5 en=1 cycles total; counter frozen while en=0; div gives 10.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Stage entries carry destination, remaining Tnew and the source registers.
package hazard_scoreboard_pkg;

  localparam int ENTRY_REG_W = 5;
  localparam int MD_CNT_W = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef logic [ENTRY_REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t   a3;
    logic [1:0] tnew;
    reg_idx_t   rs;
    reg_idx_t   rt;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide unit busy counter: loads the operation latency, then
// counts down on every pipeline advance until the unit is free.
module md_busy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  logic [MD_CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= '0;
    end else if (en) begin
      if (load) begin
        cnt_p0 <= is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
      end else if (cnt_p0 != '0) begin
        cnt_p0 <= cnt_p0 - MD_CNT_W'(1);
      end
    end
  end

  assign busy = (cnt_p0 != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Central hazard controller: tracks E/M/W destinations with remaining Tnew,
// and produces stall, D/E forwarding selects and the MDU interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W       = ENTRY_REG_W,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [REG_W-1:0] d_a3,
  input  logic [1:0]       d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_is_div,
  input  logic             d_md_use,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             md_busy
);

  // ent_p0 = E, ent_p1 = M, ent_p2 = W
  stage_t ent_p0, ent_p1, ent_p2;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Youngest stage whose destination equals s; FWD_RF when none or s is $0.
  function automatic logic [1:0] youngest(input reg_idx_t s, input stage_t e,
                                          input stage_t m, input stage_t w);
    if (s == '0)   return FWD_RF;
    if (e.a3 == s) return FWD_E;
    if (m.a3 == s) return FWD_M;
    if (w.a3 == s) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] tnew_of(input logic [1:0] code, input stage_t e,
                                         input stage_t m, input stage_t w);
    case (code)
      FWD_E:   return e.tnew;
      FWD_M:   return m.tnew;
      FWD_W:   return w.tnew;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] e_select(input reg_idx_t s, input stage_t m,
                                          input stage_t w);
    if (s == '0)   return FWD_RF;
    if (m.a3 == s) return (m.tnew == 2'd0) ? FWD_M : FWD_RF;
    if (w.a3 == s) return (w.tnew == 2'd0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

  logic [1:0] hit_rs, hit_rt, tn_rs, tn_rt;
  logic       stall_rs, stall_rt, stall_md, md_load;

  always_comb begin
    hit_rs   = youngest(d_rs, ent_p0, ent_p1, ent_p2);
    hit_rt   = youngest(d_rt, ent_p0, ent_p1, ent_p2);
    tn_rs    = tnew_of(hit_rs, ent_p0, ent_p1, ent_p2);
    tn_rt    = tnew_of(hit_rt, ent_p0, ent_p1, ent_p2);
    stall_rs = (d_tuse_rs != TUSE_NONE) && (hit_rs != FWD_RF) && (tn_rs > d_tuse_rs);
    stall_rt = (d_tuse_rt != TUSE_NONE) && (hit_rt != FWD_RF) && (tn_rt > d_tuse_rt);
    stall_md = (d_md_start || d_md_use) && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    fwd_rs_d = (hit_rs != FWD_RF && tn_rs == 2'd0) ? hit_rs : FWD_RF;
    fwd_rt_d = (hit_rt != FWD_RF && tn_rt == 2'd0) ? hit_rt : FWD_RF;
    fwd_rs_e = e_select(ent_p0.rs, ent_p1, ent_p2);
    fwd_rt_e = e_select(ent_p0.rt, ent_p1, ent_p2);
    md_load  = d_valid && d_md_start && !stall;
  end

  // D -> E -> M -> W advance; a stalled or empty D slot enters E as a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_p0 <= BUBBLE;
      ent_p1 <= BUBBLE;
      ent_p2 <= BUBBLE;
    end else if (en) begin
      ent_p2 <= '{a3: ent_p1.a3, tnew: sat_dec(ent_p1.tnew), rs: ent_p1.rs, rt: ent_p1.rt};
      ent_p1 <= '{a3: ent_p0.a3, tnew: sat_dec(ent_p0.tnew), rs: ent_p0.rs, rt: ent_p0.rt};
      if (stall || !d_valid) begin
        ent_p0 <= BUBBLE;
      end else begin
        ent_p0 <= '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt};
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (md_load),
    .is_div(d_md_is_div),
    .busy  (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized
// traffic checked against an instruction-history reference model.
module tb_hazard_scoreboard;

  logic       clk, reset, en, d_valid;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .en(en), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_is_div(d_md_is_div), .d_md_use(d_md_use), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // Reference model: the last three issued slots (index 0 = newest, in E)
  // plus the remaining MDU busy cycles.
  typedef struct {int a3; int rs; int rt; int tnew;} slot_t;
  slot_t hist[3];
  int    md_left;

  function automatic int m_tnew(int k);
    int t;
    t = hist[k].tnew - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int m_young(int s);
    if (s == 0) return -1;
    for (int k = 0; k < 3; k++) if (hist[k].a3 == s) return k;
    return -1;
  endfunction

  function automatic int m_fwd_d(int s);
    int k;
    k = m_young(s);
    return (k >= 0 && m_tnew(k) == 0) ? k + 1 : 0;
  endfunction

  function automatic bit m_src_stall(int s, int tuse);
    int k;
    k = m_young(s);
    return (tuse != 3) && (k >= 0) && (m_tnew(k) > tuse);
  endfunction

  function automatic int m_fwd_e(int s);
    if (s == 0) return 0;
    for (int k = 1; k < 3; k++)
      if (hist[k].a3 == s) return (m_tnew(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input int trs,
                       input int trt, input int a3, input int tn, input bit ms,
                       input bit mdiv, input bit mu);
    d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(trs);
    d_tuse_rt = 2'(trt); d_a3 = 5'(a3); d_tnew = 2'(tn);
    d_md_start = ms; d_md_is_div = mdiv; d_md_use = mu;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    en = 1'b1;
    nop();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_d(1, 4, 5, 1, 1, 0, 0, 1, 1, 0);  // div
    tick();
    nop();
    tick();
    tick();
    n_tests++;
    if (md_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_before: got %0b required 1", md_busy); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", md_busy); end
    n_tests++;
    if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 8'h00) begin
      n_fail++; $display("FAIL reset_fwd: got %h required 00", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e});
    end
    @(negedge clk);
    reset = 1'b1;
    set_d(1, 0, 0, 3, 3, 12, 1, 0, 0, 1);  // mflo
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_mflo_stall: got %0b required 0", stall); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 29, 0, 1, 3, 8, 2, 0, 0, 0);  // lw $8
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %0b required 0", stall); end
    tick();
    set_d(1, 8, 9, 1, 1, 10, 1, 0, 0, 0);  // addu $10, $8, $9
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b required 1", stall); end
    tick();
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release: got %0b required 0", stall); end
    n_tests++;
    if (fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL lu_fwd_rs_d: got %0d required 0", fwd_rs_d); end
    tick();
    nop();
    @(negedge clk);
    n_tests++;
    if (fwd_rs_e !== 2'd3) begin n_fail++; $display("FAIL lu_fwd_rs_e: got %0d required 3", fwd_rs_e); end
    n_tests++;
    if (fwd_rt_e !== 2'd0) begin n_fail++; $display("FAIL lu_fwd_rt_e: got %0d required 0", fwd_rt_e); end
    tick();
  endtask

  task automatic test_alu_branch();
    do_reset();
    set_d(1, 1, 2, 1, 1, 8, 1, 0, 0, 0);  // addu $8
    tick();
    set_d(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);  // beq $8, $0
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL br_stall: got %0b required 1", stall); end
    tick();
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL br_release: got %0b required 0", stall); end
    n_tests++;
    if (fwd_rs_d !== 2'd2) begin n_fail++; $display("FAIL br_fwd_rs_d: got %0d required 2", fwd_rs_d); end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    set_d(1, 1, 0, 1, 3, 9, 1, 0, 0, 0);  // ori $9
    tick();
    set_d(1, 0, 0, 3, 3, 9, 0, 0, 0, 0);  // lui $9
    tick();
    set_d(1, 9, 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL yw_fwd: got %0d required 1", fwd_rs_d); end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL yw_stall: got %0b required 0", stall); end
    do_reset();
    set_d(1, 0, 0, 3, 3, 9, 0, 0, 0, 0);  // lui $9
    tick();
    set_d(1, 1, 0, 1, 3, 9, 1, 0, 0, 0);  // ori $9
    tick();
    set_d(1, 9, 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL yw_swap_stall: got %0b required 1", stall); end
    n_tests++;
    if (fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL yw_swap_fwd: got %0d required 0", fwd_rs_d); end
    tick();
  endtask

  task automatic test_zero_unused();
    do_reset();
    set_d(1, 29, 0, 1, 3, 0, 2, 0, 0, 0);  // lw $0
    tick();
    set_d(1, 0, 0, 1, 1, 10, 1, 0, 0, 0);  // addu reading $0
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0 || fwd_rs_d !== 2'd0) begin
      n_fail++; $display("FAIL zero_reg: got stall=%0b fwd=%0d required 0/0", stall, fwd_rs_d);
    end
    tick();
    set_d(1, 29, 0, 1, 3, 8, 2, 0, 0, 0);  // lw $8
    tick();
    set_d(1, 8, 8, 3, 3, 0, 0, 0, 0, 0);   // operands unused
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0 || fwd_rs_d !== 2'd0) begin
      n_fail++; $display("FAIL unused_op: got stall=%0b fwd=%0d required 0/0", stall, fwd_rs_d);
    end
    tick();
  endtask

  task automatic test_mdu_freeze();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      set_d(1, 4, 5, 1, 1, 0, 0, 1, pass[0], 0);  // mult / div
      @(negedge clk);
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL md_issue_stall: got %0b required 0", stall); end
      tick();
      set_d(1, 0, 0, 3, 3, 12, 1, 0, 0, 1);  // mflo
      n = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (!stall) break;
        n++;
        if (pass == 0 && n == 2) begin
          en = 1'b0;
          for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (stall !== 1'b1 || md_busy !== 1'b1) begin
              n_fail++; $display("FAIL md_freeze: got stall=%0b busy=%0b required 1/1", stall, md_busy);
            end
          end
          en = 1'b1;
        end
        tick();
      end
      n_tests++;
      if (n !== (pass ? 10 : 5)) begin
        n_fail++; $display("FAIL md_stall_cycles: got %0d required %0d", n, pass ? 10 : 5);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit e_stall;
    int e_rsd, e_rtd, e_rse, e_rte;
    bit e_busy;
    do_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    md_left = 0;
    for (int it = 0; it < 600; it++) begin
      set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 1),
            $urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      e_busy  = (md_left > 0);
      e_stall = m_src_stall(d_rs, d_tuse_rs) || m_src_stall(d_rt, d_tuse_rt) ||
                ((d_md_start || d_md_use) && e_busy);
      e_rsd = m_fwd_d(d_rs);
      e_rtd = m_fwd_d(d_rt);
      e_rse = m_fwd_e(hist[0].rs);
      e_rte = m_fwd_e(hist[0].rt);
      n_tests++;
      if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall it=%0d: got %0b required %0b", it, stall, e_stall); end
      n_tests++;
      if (md_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy it=%0d: got %0b required %0b", it, md_busy, e_busy); end
      n_tests++;
      if (fwd_rs_d !== 2'(e_rsd) || fwd_rt_d !== 2'(e_rtd)) begin
        n_fail++; $display("FAIL rnd_fwd_d it=%0d: got %0d/%0d required %0d/%0d", it, fwd_rs_d, fwd_rt_d, e_rsd, e_rtd);
      end
      n_tests++;
      if (fwd_rs_e !== 2'(e_rse) || fwd_rt_e !== 2'(e_rte)) begin
        n_fail++; $display("FAIL rnd_fwd_e it=%0d: got %0d/%0d required %0d/%0d", it, fwd_rs_e, fwd_rt_e, e_rse, e_rte);
      end
      if (en) begin
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (e_stall || !d_valid) hist[0] = '{0, 0, 0, 0};
        else hist[0] = '{int'(d_a3), int'(d_rs), int'(d_rt), int'(d_tnew)};
        if (d_valid && d_md_start && !e_stall) md_left = d_md_is_div ? 10 : 5;
        else if (md_left > 0) md_left--;
      end
      tick();
    end
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1;
    nop();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_youngest();
    test_zero_unused();
    test_mdu_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
